// File: rtl/mfu_pkg.sv
// Shared MFU definitions: precision mode codes and per-mode beat helpers.
// Used by the operand packer and other MFU feeders.
package mfu_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_2B = 3'd0;
    localparam logic [MODE_W-1:0] MODE_4B = 3'd1;
    localparam logic [MODE_W-1:0] MODE_8B = 3'd2;

    typedef struct packed {
        logic [31:0]       w;
        logic [7:0]        a;
        logic [MODE_W-1:0] mode;
    } mfu_word_t;

    function automatic logic [1:0] beats_per_mode(
        input logic [MODE_W-1:0] mode
    );
        logic [1:0] idx;
        idx = 2'd0;
        unique case (1'b1)
            (mode == MODE_2B): idx = 2'd3;
            (mode == MODE_4B): idx = 2'd1;
            default:           idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Illegal codes are treated as full 8-bit precision.
    function automatic logic [MODE_W-1:0] legal_mode(
        input logic [MODE_W-1:0] mode
    );
        return (mode > MODE_8B) ? MODE_8B : mode;
    endfunction

endpackage

// File: rtl/mfu_act_replicate.sv
// Replicates an 8-bit activation across the lanes of the selected precision.
// Purely combinational; shared by MFU feeders.
module mfu_act_replicate
    import mfu_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [7:0]        a,
    output logic [7:0]        a_rep
);

    always_comb begin
        a_rep = a;
        unique case (1'b1)
            (mode == MODE_2B): a_rep = {4{a[1:0]}};
            (mode == MODE_4B): a_rep = {2{a[3:0]}};
            default:           a_rep = a;
        endcase
    end

endmodule

// File: rtl/mfu_operand_packer.sv
// Byte-stream to MFU operand word packer with valid/ready output register.
// Optional zero-word skipping is enabled by defining MFU_PACK_ZSKIP_EN.
module mfu_operand_packer
    import mfu_pkg::*;
#(
    parameter int ZCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [7:0]        in_w,
    input  logic [7:0]        in_a,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_w,
    output logic [7:0]        out_a,
    output logic [MODE_W-1:0] out_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mode_err,
    output logic [ZCNT_W-1:0] zskip_cnt
);

    logic [1:0]        beat_cnt;
    logic [MODE_W-1:0] mode_q;
    logic [7:0]        a_q;
    logic [7:0]        b0_q;
    logic [7:0]        b1_q;
    logic [7:0]        b2_q;

    logic              first;
    logic              last;
    logic              take;
    logic              load;
    logic              skip;
    logic [MODE_W-1:0] cur_mode;
    logic [7:0]        cur_a;
    logic [7:0]        rep_a;
    logic [31:0]       pack_w;
    mfu_word_t         out_q;

    // Beat 0 uses the live inputs; later beats use the latched copies.
    assign first    = (beat_cnt == 2'd0);
    assign cur_mode = first ? legal_mode(in_mode) : mode_q;
    assign cur_a    = first ? in_a : a_q;
    assign last     = (beat_cnt == beats_per_mode(cur_mode));

    always_comb begin
        pack_w = {4{in_w}};
        unique case (1'b1)
            (cur_mode == MODE_2B): pack_w = {b0_q, b1_q, b2_q, in_w};
            (cur_mode == MODE_4B): pack_w = {b0_q, b0_q, in_w, in_w};
            default:               pack_w = {4{in_w}};
        endcase
    end

    mfu_act_replicate u_act (
        .mode  (cur_mode),
        .a     (cur_a),
        .a_rep (rep_a)
    );

`ifdef MFU_PACK_ZSKIP_EN
    assign skip = last && (pack_w == 32'd0);
`else
    assign skip = 1'b0;
`endif

    // Only a final beat that must load a full output register stalls.
    assign in_ready = !(last && !skip && out_valid && !out_ready);
    assign take     = in_valid && in_ready;
    assign load     = take && last && !skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 2'd0;
            mode_q   <= MODE_2B;
            a_q      <= 8'd0;
            b0_q     <= 8'd0;
            b1_q     <= 8'd0;
            b2_q     <= 8'd0;
        end else if (take) begin
            beat_cnt <= last ? 2'd0 : beat_cnt + 2'd1;
            if (first) begin
                mode_q <= cur_mode;
                a_q    <= in_a;
            end
            if (beat_cnt == 2'd0) b0_q <= in_w;
            if (beat_cnt == 2'd1) b1_q <= in_w;
            if (beat_cnt == 2'd2) b2_q <= in_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_err <= 1'b0;
        end else if (take && first && (in_mode > MODE_8B)) begin
            mode_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_q     <= '{w: pack_w, a: rep_a, mode: cur_mode};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_w    = out_q.w;
    assign out_a    = out_q.a;
    assign out_mode = out_q.mode;

`ifdef MFU_PACK_ZSKIP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zskip_cnt <= '0;
        end else if (take && skip && (zskip_cnt != '1)) begin
            zskip_cnt <= zskip_cnt + 1'b1;
        end
    end
`else
    assign zskip_cnt = '0;
`endif

endmodule

// File: tb/tb_mfu_operand_packer.sv
// Scoreboard bench for mfu_operand_packer: directed cases plus random
// traffic against a byte-level reference model.
module tb_mfu_operand_packer;

    localparam int ZCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        in_mode;
    logic [7:0]        in_w;
    logic [7:0]        in_a;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       out_w;
    logic [7:0]        out_a;
    logic [2:0]        out_mode;
    logic              out_valid;
    logic              out_ready;
    logic              mode_err;
    logic [ZCNT_W-1:0] zskip_cnt;

    always #5 clk = ~clk;

    mfu_operand_packer #(.ZCNT_W(ZCNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_mode   (in_mode),
        .in_w      (in_w),
        .in_a      (in_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_w     (out_w),
        .out_a     (out_a),
        .out_mode  (out_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mode_err  (mode_err),
        .zskip_cnt (zskip_cnt)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [7:0]  a;
        logic [2:0]  m;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ready_mode = 0;

    int          m_cnt = 0;
    int          m_mode = 0;
    logic [7:0]  m_a = 8'd0;
    logic [7:0]  m_b[4];
    bit          exp_err = 1'b0;
    int          exp_skip = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: collect bytes of a word, then build it from lane rules.
    function automatic void model_beat(int mode, logic [7:0] w,
                                       logic [7:0] a);
        int          pm;
        int          n;
        int          lane;
        logic [31:0] word;
        logic [7:0]  ra;
        exp_t        e;
        if (m_cnt == 0) begin
            m_mode = mode;
            m_a    = a;
            if (mode > 2) exp_err = 1'b1;
        end
        m_b[m_cnt] = w;
        m_cnt++;
        pm = (m_mode > 2) ? 2 : m_mode;
        n  = (pm == 0) ? 4 : (pm == 1) ? 2 : 1;
        if (m_cnt == n) begin
            m_cnt = 0;
            word  = 32'd0;
            for (int k = 0; k < 4; k++) begin
                lane = (pm == 0) ? k : (pm == 1) ? k / 2 : 0;
                word = (word << 8) | 32'(m_b[lane]);
            end
            if (pm == 0)      ra = 8'((m_a & 8'h03) * 8'h55);
            else if (pm == 1) ra = 8'((m_a & 8'h0F) * 8'h11);
            else              ra = m_a;
`ifdef MFU_PACK_ZSKIP_EN
            if (word == 32'd0) begin
                if (exp_skip < (1 << ZCNT_W) - 1) exp_skip++;
                return;
            end
`endif
            e.w = word;
            e.a = ra;
            e.m = 3'(pm);
            q.push_back(e);
        end
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      out_ready = 1'b1;
            else if (ready_mode == 2) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic stall_prev = 1'b0;
    exp_t held;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_w", 64'(out_w), 64'(held.w));
                check("hold_a", 64'(out_a), 64'(held.a));
                check("hold_mode", 64'(out_mode), 64'(held.m));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h want none",
                             out_w);
                end else begin
                    e = q.pop_front();
                    check("out_w", 64'(out_w), 64'(e.w));
                    check("out_a", 64'(out_a), 64'(e.a));
                    check("out_mode", 64'(out_mode), 64'(e.m));
                end
            end
            stall_prev = out_valid && !out_ready;
            held.w = out_w;
            held.a = out_a;
            held.m = out_mode;
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int mode, input logic [7:0] w,
                             input logic [7:0] a, output int waited);
        waited   = 0;
        in_mode  = mode[2:0];
        in_w     = w;
        in_a     = a;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(mode, w, a);
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0 want 1");
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        ready_mode = 0;
        in_valid   = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int wt;
        int md;
        logic [7:0] wb;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_mode  = 3'd0;
        in_w     = 8'd0;
        in_a     = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_w", 64'(out_w), 64'd0);
        check("rst_out_a", 64'(out_a), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_mode_err", 64'(mode_err), 64'd0);
        check("rst_zskip", 64'(zskip_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // 8b single word, then back-to-back at full rate.
        send_beat(2, 8'hA5, 8'h3C, wt);
        check("lat_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            send_beat(2, 8'($urandom), 8'($urandom), wt);
            check("tput_wait", 64'(wt), 64'd0);
        end
        idle(2);

        // 2b word.
        send_beat(0, 8'h12, 8'h02, wt);
        send_beat(0, 8'h34, 8'hFF, wt);
        send_beat(0, 8'h56, 8'h11, wt);
        send_beat(0, 8'h78, 8'h33, wt);
        idle(3);

        // 4b word with mode change on beat 1.
        send_beat(1, 8'h9C, 8'h07, wt);
        send_beat(2, 8'h3E, 8'hE1, wt);
        idle(3);
        drain();

        // Backpressure in 8b mode.
        ready_mode = 2;
        idle(2);
        send_beat(2, 8'h11, 8'h01, wt);
        check("bp_first_wait", 64'(wt), 64'd0);
        in_mode  = 3'd2;
        in_w     = 8'h22;
        in_a     = 8'h02;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_w", 64'(out_w), 64'h11111111);
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        send_beat(2, 8'h22, 8'h02, wt);
        send_beat(2, 8'h33, 8'h03, wt);
        drain();

        // Illegal mode.
        send_beat(5, 8'h01, 8'h9D, wt);
        idle(2);
        check("mode_err_set", 64'(mode_err), 64'd1);
        idle(2);
        check("mode_err_sticky", 64'(mode_err), 64'd1);
        drain();

`ifdef MFU_PACK_ZSKIP_EN
        send_beat(2, 8'h00, 8'h44, wt);
        idle(3);
        check("zskip_one", 64'(zskip_cnt), 64'(exp_skip));
        check("zskip_no_word", 64'(q.size()), 64'd0);
`endif

        // Reset in the middle of a 2b word.
        send_beat(0, 8'hAA, 8'h01, wt);
        send_beat(0, 8'hBB, 8'h01, wt);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_err", 64'(mode_err), 64'd0);
        check("mid_rst_zskip", 64'(zskip_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt    = 0;
        exp_err  = 1'b0;
        exp_skip = 0;
        q.delete();
        idle(1);
        send_beat(0, 8'hFF, 8'h03, wt);
        send_beat(0, 8'h00, 8'h00, wt);
        send_beat(0, 8'hFF, 8'h00, wt);
        send_beat(0, 8'h00, 8'h00, wt);
        idle(1);
        check("post_rst_w", 64'(out_w), 64'hFF00FF00);
        drain();

        // Random traffic with random backpressure and gaps.
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            md = $urandom_range(0, 9);
            if (md == 9) md = 3 + $urandom_range(0, 4);
            else md = md % 3;
            wb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            send_beat(md, wb, 8'($urandom), wt);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        check("final_mode_err", 64'(mode_err), 64'(exp_err));
        check("final_zskip", 64'(zskip_cnt), 64'(exp_skip));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mfu_operand_packer.md
Name: mfu_operand_packer

Overview:
Producer-side front end for the multi-precision fusion unit (MFU) in sparse_dnn.
- Accepts a byte-wide weight/activation stream and assembles one MFU operand word per beat group: 32-bit weight word plus 8-bit activation, in the layout the MFU expects for the selected precision.
- Performs the bit replication the MFU relies on.
- Presents each packed word, together with its mode, over a valid/ready interface to the MFU pipeline stage.

Parameters:
- ZCNT_W, 16, width of zero-skip counter (used only with optional feature).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- in_mode  in  3  0=2bx2b, 1=4bx4b, 2=8bx8b; sampled on first beat of each word.
- in_w  in  8  weight byte for this beat.
- in_a  in  8  activation; sampled on first beat of each word.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- out_w  out  32  packed/replicated weight word.
- out_a  out  8  replicated activation.
- out_mode  out  3  mode of the word on out_w.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- mode_err  out  1  sticky; set when an illegal mode (3..7) is sampled.
- zskip_cnt  out  ZCNT_W  count of dropped all-zero words.

Behaviour:
- Reset values: out_valid=0, out_w=0, out_a=0, out_mode=0, mode_err=0, zskip_cnt=0, beat_cnt=0, partial word discarded.
- Beats per word: mode 0 = 4, mode 1 = 2, mode 2 = 1. Illegal mode is packed as mode 2, reported as out_mode=2, and sets mode_err.
- Mode and activation are latched on beat 0. in_mode/in_a on later beats of the same word are ignored.
- Weight packing, beats b0..b3 in arrival order:
  - 2b: out_w = {b0,b1,b2,b3}; w_k occupies bits [31-2k:30-2k].
  - 4b: out_w = {b0,b0,b1,b1}.
  - 8b: out_w = {b0,b0,b0,b0}.
- Activation replication:
  - 2b: {4{a[1:0]}}.
  - 4b: {2{a[3:0]}}.
  - 8b: a[7:0].
- Structure: assembly register plus one output register. The final beat writes the completed word into the output register on the accepting edge, so out_valid rises the next cycle. Latency = 1 cycle after the final beat.
- in_ready = !(beat_is_final && out_valid && !out_ready). Non-final beats are never stalled. Combinational from out_ready by design.
- Simultaneous drain and final beat: output register is reloaded and out_valid stays 1. This gives full throughput of 1 word/cycle in 8b mode.
- beat_cnt wraps to 0 after the final beat.
- out_* hold stable while out_valid && !out_ready.
- Reset mid-word or mid-stall: all state cleared; the next beat is treated as beat 0.

Optional Feature:
MFU_PACK_ZSKIP_EN
- Defined: a completed word whose 32-bit packed weight is 0 is not written to the output register. zskip_cnt increments (saturating at all-ones). in_ready is not stalled for that final beat.
- Undefined: all words are presented; zskip_cnt is tied to 0.

Decomposition:
- Package mfu_pkg: MODE_2B=0, MODE_4B=1, MODE_8B=2, MODE_W=3; function beats_per_mode(mode) returning final-beat index (3/1/0, illegal→0).
- Sub-module mfu_act_replicate: combinational activation replication by mode, reusable by other MFU feeders.

Test Plan:
1. 8b: in_w=0xA5, in_a=0x3C, out_ready=1 -> next cycle out_valid=1, out_w=0xA5A5A5A5, out_a=0x3C, out_mode=2; back-to-back beats yield one word per cycle.
2. 2b: beats 0x12,0x34,0x56,0x78, in_a=0x02 on beat 0 -> out_w=0x12345678, out_a=0xAA, out_mode=0, exactly one out_valid pulse.
3. 4b: beats 0x9C,0x3E, in_a=0x07, in_mode toggled to 2 on beat 1 -> out_w=0x9C9C3E3E, out_a=0x77, out_mode=1 (mid-word mode change ignored).
4. Backpressure, 8b, out_ready=0, 3 beats offered -> first accepted, in_ready=0 thereafter, out_w stable; raise out_ready -> remaining words drain in order, no loss or duplication.
5. Reset after 2 of 4 beats in 2b mode -> out_valid=0; next 4 beats 0xFF,0x00,0xFF,0x00 -> out_w=0xFF00FF00.
6. in_mode=5 with in_w=0x01 -> mode_err=1 (sticky), out_w=0x01010101, out_mode=2. With MFU_PACK_ZSKIP_EN, 8b in_w=0x00 -> no out_valid, zskip_cnt=1.
